// File: rtl/dmem_atomic_responder_if.sv
// dmem_atomic_responder_if: MEM-stage request, memory port and snoop signals of one core's data side.
interface dmem_atomic_responder_if #(parameter int WORD_W = 32);
    logic              dmemren, dmemwen, datomic, halt, dhit;
    logic              dREN, dWEN, dwait, snoop_wen;
    logic [WORD_W-1:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload, snoop_addr;
    modport slave (
        input  dmemren, dmemwen, datomic, dmemaddr, dmemstore, halt, dwait, dload, snoop_wen, snoop_addr,
        output dhit, dmemload, dREN, dWEN, daddr, dstore
    );
    modport master (
        output dmemren, dmemwen, datomic, dmemaddr, dmemstore, halt, dwait, dload, snoop_wen, snoop_addr,
        input  dhit, dmemload, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/dmem_atomic_responder.sv
// dmem_atomic_responder: sequences MEM-stage requests onto the dcache port and owns the LL/SC link register.
module dmem_atomic_responder #(
    parameter int WORD_W   = 32,
    parameter int ADDR_LSB = 2
) (
    input logic                    CLK,
    input logic                    nRST,
    dmem_atomic_responder_if.slave bus
);
    localparam int LA_W = WORD_W - ADDR_LSB;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t          state;
    logic            is_wr, is_at, link_valid;
    logic [LA_W-1:0] link_addr, req_word, cur_word, snoop_word;
    logic            req, sc_fail, complete, ll_done, link_clear;
    always_comb begin
        req_word   = LA_W'(bus.dmemaddr >> ADDR_LSB);
        cur_word   = LA_W'(bus.daddr >> ADDR_LSB);
        snoop_word = LA_W'(bus.snoop_addr >> ADDR_LSB);
        req        = state == IDLE && !bus.halt && (bus.dmemren || bus.dmemwen);
        sc_fail    = req && bus.dmemwen && bus.datomic && !(link_valid && link_addr == req_word);
        complete   = state == ACCESS && !bus.dwait;
        ll_done    = complete && !is_wr && is_at;
        link_clear = bus.halt || (bus.snoop_wen && snoop_word == link_addr) || sc_fail ||
                     (complete && is_wr && (is_at || cur_word == link_addr));
    end
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= IDLE;
            is_wr        <= 1'b0;
            is_at        <= 1'b0;
            link_valid   <= 1'b0;
            link_addr    <= '0;
            bus.dhit     <= 1'b0;
            bus.dmemload <= '0;
            bus.dREN     <= 1'b0;
            bus.dWEN     <= 1'b0;
            bus.daddr    <= '0;
            bus.dstore   <= '0;
        end else begin
            bus.dhit <= 1'b0;
            // A snoop hitting the word being linked in the same cycle wins over the LL set.
            if (ll_done) begin
                link_valid <= !(bus.halt || (bus.snoop_wen && snoop_word == cur_word));
                link_addr  <= cur_word;
            end else if (link_clear) begin
                link_valid <= 1'b0;
            end
            case (state)
                IDLE: if (req) begin
                    bus.daddr  <= bus.dmemaddr;
                    bus.dstore <= bus.dmemstore;
                    is_wr      <= bus.dmemwen;
                    is_at      <= bus.datomic;
                    if (sc_fail) begin
                        bus.dmemload <= '0;
                        bus.dhit     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        bus.dREN <= !bus.dmemwen;
                        bus.dWEN <= bus.dmemwen;
                        state    <= ACCESS;
                    end
                end
                ACCESS: if (!bus.dwait) begin
                    bus.dREN <= 1'b0;
                    bus.dWEN <= 1'b0;
                    bus.dhit <= 1'b1;
                    state    <= DONE;
                    if (!is_wr) bus.dmemload <= bus.dload;
                    else if (is_at) bus.dmemload <= WORD_W'(1);
                end
                // DONE is a bubble so the still-held request is not re-issued before EX/MEM advances.
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_atomic_responder.sv
// tb_dmem_atomic_responder: directed vector table, corner sequences and random LL/SC traffic vs a link model.
module tb_dmem_atomic_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    dmem_atomic_responder_if #(.WORD_W(32)) bus();
    dmem_atomic_responder #(.WORD_W(32), .ADDR_LSB(2)) dut (.CLK(clk), .nRST(rst_n), .bus(bus));
    typedef struct {
        logic        wr, at;
        logic [31:0] addr, store;
        int          waits;
        logic [31:0] ld;
        logic        pre, snp;
        logic [31:0] saddr, exp_load;
        logic        exp_acc;
    } vec_t;
    int checks = 0;
    int fails = 0;
    logic        m_lv;
    logic [29:0] m_la;
    logic [31:0] m_load;
    vec_t        tbl[23];
    logic [31:0] pool[4] = '{32'h200, 32'h204, 32'h202, 32'h300};
    function automatic vec_t mk(input logic wr, at, input logic [31:0] addr, store, input int waits,
                                input logic [31:0] ld, input logic pre, snp, input logic [31:0] saddr, el,
                                input logic ea);
        vec_t v;
        v.wr = wr; v.at = at; v.addr = addr; v.store = store; v.waits = waits; v.ld = ld;
        v.pre = pre; v.snp = snp; v.saddr = saddr; v.exp_load = el; v.exp_acc = ea;
        return v;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask
    // Link register semantics at transaction level: what the pipeline sees and whether memory is touched.
    task automatic model(input vec_t v, output logic [31:0] el, output logic ea);
        logic [29:0] aw, sw;
        aw = v.addr[31:2];
        sw = v.saddr[31:2];
        if (v.pre && sw == m_la) m_lv = 1'b0;
        if (v.wr && v.at) begin
            ea = m_lv && m_la == aw;
            m_load = ea ? 32'd1 : 32'd0;
            m_lv = 1'b0;
        end else if (v.wr) begin
            ea = 1'b1;
            if ((v.snp && sw == m_la) || aw == m_la) m_lv = 1'b0;
        end else begin
            ea = 1'b1;
            m_load = v.ld;
            if (v.snp && sw == m_la) m_lv = 1'b0;
            if (v.at) begin
                m_lv = !(v.snp && v.waits == 0 && sw == aw);
                m_la = aw;
            end
        end
        el = m_load;
    endtask
    task automatic run(input vec_t v, input logic [31:0] el, input logic ea, input string tag);
        int   cyc, str;
        logic got, bad;
        if (v.pre) begin
            bus.snoop_wen = 1'b1; bus.snoop_addr = v.saddr;
            @(negedge clk);
            bus.snoop_wen = 1'b0;
        end
        bus.dmemren = !v.wr; bus.dmemwen = v.wr; bus.datomic = v.at;
        bus.dmemaddr = v.addr; bus.dmemstore = v.store; bus.dwait = 1'b1; bus.dload = v.ld;
        cyc = 0; str = 0; got = 1'b0; bad = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            bus.snoop_wen = 1'b0;
            if (bus.dhit) begin
                got = 1'b1;
                if (bus.dREN || bus.dWEN) bad = 1'b1;
            end else if (bus.dREN || bus.dWEN) begin
                str++;
                if (bus.dREN == v.wr || bus.dWEN != v.wr || bus.daddr != v.addr || (v.wr && bus.dstore != v.store))
                    bad = 1'b1;
                bus.dwait = str <= v.waits;
                if (str == 1 && v.snp) begin
                    bus.snoop_wen = 1'b1; bus.snoop_addr = v.saddr;
                end
            end
        end
        bus.dmemren = 1'b0; bus.dmemwen = 1'b0; bus.datomic = 1'b0; bus.dwait = 1'b1;
        chk({tag, " dhit"}, 32'(got), 32'd1);
        chk({tag, " latency"}, cyc, ea ? v.waits + 2 : 1);
        chk({tag, " strobes"}, str, ea ? v.waits + 1 : 0);
        chk({tag, " dmemload"}, bus.dmemload, el);
        chk({tag, " port"}, 32'(bad), 32'd0);
        @(negedge clk);
        chk({tag, " dhit_pulse"}, 32'(bus.dhit), 32'd0);
        bus.snoop_wen = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        m_lv = 1'b0; m_la = '0; m_load = '0;
    endtask
    initial begin
        logic [31:0] el;
        logic        ea;
        int          cyc, hits, rens, last, gap_bad, overlap, cnt;
        vec_t        v;
        bus.dmemren = 0; bus.dmemwen = 0; bus.datomic = 0; bus.dmemaddr = 0; bus.dmemstore = 0;
        bus.halt = 0; bus.dwait = 1; bus.dload = 0; bus.snoop_wen = 0; bus.snoop_addr = 0;
        m_lv = 1'b0; m_la = '0; m_load = '0;
        tbl[0]  = mk(0, 0, 'h100, 0, 3, 'hDEADBEEF, 0, 0, 0, 'hDEADBEEF, 1);
        tbl[1]  = mk(0, 1, 'h200, 0, 0, 'h11, 0, 0, 0, 'h11, 1);
        tbl[2]  = mk(1, 1, 'h200, 5, 1, 0, 0, 0, 0, 1, 1);
        tbl[3]  = mk(1, 1, 'h200, 6, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 'h200, 0, 0, 'h22, 0, 0, 0, 'h22, 1);
        tbl[5]  = mk(1, 1, 'h200, 5, 0, 0, 1, 0, 'h200, 0, 0);
        tbl[6]  = mk(0, 1, 'h200, 0, 2, 'h33, 0, 0, 0, 'h33, 1);
        tbl[7]  = mk(1, 1, 'h200, 5, 0, 0, 1, 0, 'h204, 1, 1);
        tbl[8]  = mk(0, 1, 'h200, 0, 0, 'h44, 0, 0, 0, 'h44, 1);
        tbl[9]  = mk(1, 1, 'h200, 5, 0, 0, 1, 0, 'h202, 0, 0);
        tbl[10] = mk(0, 1, 'h200, 0, 0, 'h55, 0, 0, 0, 'h55, 1);
        tbl[11] = mk(1, 1, 'h300, 7, 0, 0, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 1, 'h400, 0, 0, 'h66, 0, 1, 'h400, 'h66, 1);
        tbl[13] = mk(1, 1, 'h400, 8, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 1, 'h400, 0, 0, 'h77, 0, 1, 'h404, 'h77, 1);
        tbl[15] = mk(1, 1, 'h400, 9, 0, 0, 0, 0, 0, 1, 1);
        tbl[16] = mk(0, 1, 'h500, 0, 0, 'h88, 0, 0, 0, 'h88, 1);
        tbl[17] = mk(1, 0, 'h500, 1, 1, 0, 0, 0, 0, 'h88, 1);
        tbl[18] = mk(1, 1, 'h500, 2, 0, 0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 1, 'h600, 0, 1, 'h99, 0, 1, 'h600, 'h99, 1);
        tbl[20] = mk(1, 1, 'h600, 3, 0, 0, 0, 0, 0, 1, 1);
        tbl[21] = mk(0, 1, 'h700, 0, 0, 'hAA, 0, 0, 0, 'hAA, 1);
        tbl[22] = mk(1, 1, 'h700, 4, 2, 0, 0, 1, 'h700, 1, 1);
        @(negedge clk);
        @(negedge clk);
        chk("reset dhit", 32'(bus.dhit), 0);
        chk("reset dREN", 32'(bus.dREN), 0);
        chk("reset dWEN", 32'(bus.dWEN), 0);
        chk("reset daddr", bus.daddr, 0);
        chk("reset dstore", bus.dstore, 0);
        chk("reset dmemload", bus.dmemload, 0);
        rst_n = 1'b1;
        @(negedge clk);
        foreach (tbl[i]) begin
            model(tbl[i], el, ea);
            run(tbl[i], tbl[i].exp_load, tbl[i].exp_acc, $sformatf("vec%0d", i));
        end
        // Async reset mid-ACCESS must drop strobes and the link.
        v = mk(0, 1, 'h900, 0, 0, 'h12, 0, 0, 0, 0, 0);
        run(v, 'h12, 1, "ll_before_reset");
        bus.dmemren = 1; bus.dmemaddr = 'h100; bus.dwait = 1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset dREN", 32'(bus.dREN), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset dREN", 32'(bus.dREN), 0);
        chk("async_reset dWEN", 32'(bus.dWEN), 0);
        chk("async_reset dhit", 32'(bus.dhit), 0);
        chk("async_reset dmemload", bus.dmemload, 0);
        bus.dmemren = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(mk(1, 1, 'h900, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, "sc_after_reset");
        // Halt clears the link.
        run(mk(0, 1, 'hA00, 0, 0, 'h34, 0, 0, 0, 0, 0), 'h34, 1, "ll_before_halt");
        bus.halt = 1;
        @(negedge clk);
        bus.halt = 0;
        run(mk(1, 1, 'hA00, 1, 0, 0, 0, 0, 0, 0, 0), 0, 0, "sc_after_halt");
        // Halt blocks a new request until released.
        bus.halt = 1; bus.dmemren = 1; bus.dmemaddr = 'h104; bus.dload = 'h1234; bus.dwait = 0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.dREN || bus.dhit) cnt++;
        end
        chk("halt_blocks", cnt, 0);
        bus.halt = 0;
        cyc = 0;
        while (!bus.dhit && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("halt_release dhit", 32'(bus.dhit), 1);
        chk("halt_release dmemload", bus.dmemload, 'h1234);
        bus.dmemren = 0;
        @(negedge clk);
        // Halt during ACCESS: finish the access, then accept nothing.
        bus.dmemren = 1; bus.dmemaddr = 'h108; bus.dload = 'h4321; bus.dwait = 1;
        cyc = 0;
        while (!bus.dREN && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        bus.halt = 1; bus.dwait = 0;
        @(negedge clk);
        chk("halt_in_access dhit", 32'(bus.dhit), 1);
        chk("halt_in_access dmemload", bus.dmemload, 'h4321);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.dREN || bus.dhit) cnt++;
        end
        chk("halt_after_access", cnt, 0);
        bus.dmemren = 0; bus.halt = 0;
        @(negedge clk);
        // Held request: one strobe per dhit, three-cycle period with the DONE bubble.
        bus.dmemren = 1; bus.dmemaddr = 'h100; bus.dwait = 0; bus.dload = 'h5A;
        hits = 0; rens = 0; last = 0; gap_bad = 0; overlap = 0; cyc = 0;
        while (hits < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (bus.dREN) rens++;
            if (bus.dhit) begin
                if (bus.dREN) overlap++;
                if (hits > 0 && cyc - last != 3) gap_bad++;
                last = cyc;
                hits++;
            end
        end
        bus.dmemren = 0; bus.dwait = 1;
        chk("held hits", hits, 4);
        chk("held strobes", rens, 4);
        chk("held gap", gap_bad, 0);
        chk("held overlap", overlap, 0);
        chk("held dmemload", bus.dmemload, 'h5A);
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 200; i++) begin
            v = mk($urandom_range(0, 1), $urandom_range(0, 1), pool[$urandom_range(0, 3)], $urandom,
                   $urandom_range(0, 3), $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   pool[$urandom_range(0, 3)], 0, 0);
            model(v, el, ea);
            run(v, el, ea, $sformatf("rnd%0d", i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
